// File: rtl/turing_loader.sv
// Turing machine loader: streams rule and tape words into a press-driven
// machine front panel, then optionally single-steps it until halt or limit.
module turing_loader #(
  parameter int AW        = 6,
  parameter int PRESS_CYC = 2,
  parameter int GAP_CYC   = 2,
  parameter int FILL_CYC  = 2**AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          auto_run,
  input  logic [15:0]   max_steps,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          Compute_done,
  output logic [AW-1:0] input_data,
  output logic          Next,
  output logic          Done,
  output logic          busy,
  output logic          loaded,
  output logic          finished,
  output logic [15:0]   step_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACC,
    S_PRESS,
    S_GAP,
    S_DPRESS,
    S_DGAP,
    S_FILL,
    S_RPRESS,
    S_RGAP,
    S_FIN
  } state_t;

  localparam logic [31:0] P_END = 32'(PRESS_CYC - 1);
  localparam logic [31:0] G_END = 32'(GAP_CYC - 1);
  localparam logic [31:0] F_END = 32'(FILL_CYC - 1);

  state_t        state_q;
  logic          seg_q;
  logic          last_q;
  logic [31:0]   cnt_q;
  logic [31:0]   cnt_d;
  logic [AW-1:0] word_q;
  logic          ready_q;
  logic          next_q;
  logic          done_q;
  logic          busy_q;
  logic          loaded_q;
  logic          fin_q;
  logic [15:0]   step_q;
  logic [15:0]   step_d;
  logic          stop_d;

  assign cnt_d  = cnt_q + 32'd1;
  assign step_d = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
  assign stop_d = Compute_done ||
                  ((max_steps != 16'd0) && (step_q >= max_steps));

  assign ld_ready   = ready_q;
  assign input_data = word_q;
  assign Next       = next_q;
  assign Done       = done_q;
  assign busy       = busy_q;
  assign loaded     = loaded_q;
  assign finished   = fin_q;
  assign step_count = step_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      seg_q    <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      word_q   <= '0;
      ready_q  <= 1'b0;
      next_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
      fin_q    <= 1'b0;
      step_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ACC;
            seg_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ACC: begin
          if (ld_valid && ready_q) begin
            word_q  <= ld_data;
            last_q  <= ld_last;
            ready_q <= 1'b0;
            next_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (cnt_q == P_END) begin
            next_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_GAP: begin
          if (cnt_q == G_END) begin
            cnt_q <= '0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DPRESS;
            end else begin
              ready_q <= 1'b1;
              state_q <= S_ACC;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DPRESS: begin
          if (cnt_q == P_END) begin
            done_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_DGAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DGAP: begin
          if (cnt_q == G_END) begin
            cnt_q <= '0;
            if (seg_q) begin
              state_q <= S_FILL;
            end else begin
              seg_q   <= 1'b1;
              ready_q <= 1'b1;
              state_q <= S_ACC;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_FILL: begin
          // loaded stays up; FILL doubles as the wait-for-auto_run hold
          if (loaded_q || cnt_q == F_END) begin
            loaded_q <= 1'b1;
            if (auto_run) begin
              next_q  <= 1'b1;
              step_q  <= step_d;
              cnt_q   <= '0;
              state_q <= S_RPRESS;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RPRESS: begin
          if (cnt_q == P_END) begin
            next_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_RGAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RGAP: begin
          if (cnt_q == G_END) begin
            cnt_q <= '0;
            if (stop_d) begin
              fin_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FIN;
            end else begin
              next_q  <= 1'b1;
              step_q  <= step_d;
              state_q <= S_RPRESS;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_FIN: begin
          state_q <= S_FIN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turing_loader.sv
// Scoreboard bench for turing_loader: drivers queue expected press events,
// a negedge monitor reconstructs pulses from the pins and retires them.
module tb_turing_loader;

  localparam int AW = 6;
  localparam int PC = 2;
  localparam int GC = 2;
  localparam int FC = 64;

  localparam int K_NEXT = 0;
  localparam int K_DONE = 1;
  localparam int K_RUN  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          auto_run = 1'b0;
  logic [15:0]   max_steps = '0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          Compute_done = 1'b0;
  logic [AW-1:0] input_data;
  logic          Next;
  logic          Done;
  logic          busy;
  logic          loaded;
  logic          finished;
  logic [15:0]   step_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int kind;
    int data;
  } ev_t;

  ev_t exp_q[$];

  always #5 clock = ~clock;

  turing_loader #(
    .AW(AW), .PRESS_CYC(PC), .GAP_CYC(GC), .FILL_CYC(FC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .auto_run(auto_run),
    .max_steps(max_steps),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .ld_ready(ld_ready),
    .Compute_done(Compute_done),
    .input_data(input_data),
    .Next(Next),
    .Done(Done),
    .busy(busy),
    .loaded(loaded),
    .finished(finished),
    .step_count(step_count)
  );

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int k, input int d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_end(input int k, input int d, input int wd);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_pulse", k, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("pulse_kind", k, e.kind);
    if (e.kind == K_NEXT) chk("pulse_data", d, e.data);
    chk("pulse_width", wd, PC);
  endtask

  // monitor
  logic in_n = 1'b0;
  logic in_d = 1'b0;
  logic meas = 1'b0;
  int   wn, wd, dat, kind, gap_left, lcnt, dcnt;

  always @(negedge clock) begin
    if (reset) begin
      in_n = 1'b0;
      in_d = 1'b0;
      meas = 1'b0;
      gap_left = 0;
      dcnt = 0;
    end else begin
      if (Next && Done) chk("next_done_exclusive", 1, 0);
      if (Next) begin
        if (!in_n) begin
          in_n = 1'b1;
          wn = 1;
          dat = int'(input_data);
          kind = loaded ? K_RUN : K_NEXT;
        end else begin
          wn++;
          chk("press_data_hold", int'(input_data), dat);
        end
      end else if (in_n) begin
        in_n = 1'b0;
        pulse_end(kind, dat, wn);
        gap_left = GC - 1;
        chk("gap_data_hold", int'(input_data), dat);
      end else if (gap_left > 0) begin
        gap_left--;
        chk("gap_data_hold", int'(input_data), dat);
      end
      if (Done) begin
        if (!in_d) begin
          in_d = 1'b1;
          wd = 1;
        end else begin
          wd++;
        end
      end else if (in_d) begin
        in_d = 1'b0;
        pulse_end(K_DONE, 0, wd);
        dcnt++;
        if (dcnt == 2) begin
          meas = 1'b1;
          lcnt = 1;
        end
      end else if (meas) begin
        if (loaded) begin
          chk("fill_length", lcnt, GC + FC);
          meas = 1'b0;
        end else begin
          lcnt++;
          if (lcnt > GC + FC + 8) begin
            chk("fill_length", lcnt, GC + FC);
            meas = 1'b0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    ld_valid = 1'b0;
    auto_run = 1'b0;
    Compute_done = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("rst_ld_ready", int'(ld_ready), 0);
    chk("rst_input_data", int'(input_data), 0);
    chk("rst_next", int'(Next), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_loaded", int'(loaded), 0);
    chk("rst_finished", int'(finished), 0);
    chk("rst_step_count", int'(step_count), 0);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_word(input int d, input bit last, input int idle_max);
    int n;
    repeat ($urandom_range(0, idle_max)) @(negedge clock);
    ld_valid = 1'b1;
    ld_data = AW'(d);
    ld_last = last;
    n = 0;
    while (!ld_ready) begin
      @(negedge clock);
      n++;
      if (n > 200) begin
        chk("ready_timeout", 0, 1);
        ld_valid = 1'b0;
        return;
      end
    end
    push_ev(K_NEXT, d);
    if (last) push_ev(K_DONE, 0);
    @(negedge clock);
    ld_valid = 1'b0;
  endtask

  task automatic send_seg(input int w[$], input int idle_max);
    foreach (w[i]) send_word(w[i], (i == w.size() - 1), idle_max);
  endtask

  task automatic wait_finish(input int steps);
    int n;
    n = 0;
    while (!finished && n < 1000) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    chk("finished", int'(finished), 1);
    chk("busy_at_fin", int'(busy), 0);
    chk("loaded_at_fin", int'(loaded), 1);
    chk("step_count", int'(step_count), steps);
    chk("next_at_fin", int'(Next), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic rand_words(output int w[$], input int lo, input int hi);
    w.delete();
    repeat ($urandom_range(lo, hi)) w.push_back(int'($urandom_range(0, 63)));
  endtask

  task automatic run_random();
    int r[$];
    int t[$];
    int ms;
    rand_words(r, 1, 6);
    rand_words(t, 1, 6);
    ms = int'($urandom_range(1, 4));
    max_steps = 16'(ms);
    auto_run = 1'b1;
    do_start();
    send_seg(r, 3);
    send_seg(t, 3);
    repeat (ms) push_ev(K_RUN, 0);
    wait_finish(ms);
  endtask

  initial begin
    int n;
    int r[$];
    int t[$];

    // fixed streams, idle host, halt after third step
    do_reset();
    do_start();
    for (int i = 0; i < 10; i++) begin
      chk("idle_ready", int'(ld_ready), 1);
      chk("idle_next", int'(Next), 0);
      @(negedge clock);
    end
    r = '{2, 5, 1, 3};
    send_seg(r, 0);
    auto_run = 1'b1;
    max_steps = 16'd0;
    t = '{8, 1, 0};
    send_seg(t, 0);
    repeat (3) push_ev(K_RUN, 0);
    n = 0;
    while (step_count != 16'd3 && n < 500) begin
      @(negedge clock);
      n++;
    end
    Compute_done = 1'b1;
    wait_finish(3);

    // step limit, with loaded held while auto_run is low
    do_reset();
    max_steps = 16'd5;
    do_start();
    rand_words(r, 1, 5);
    rand_words(t, 1, 5);
    send_seg(r, 2);
    send_seg(t, 2);
    n = 0;
    while (!loaded && n < 300) begin
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("hold_next", int'(Next), 0);
      chk("hold_loaded", int'(loaded), 1);
      chk("hold_busy", int'(busy), 1);
      @(negedge clock);
    end
    repeat (5) push_ev(K_RUN, 0);
    auto_run = 1'b1;
    wait_finish(5);

    // randomized full sequences
    for (int k = 0; k < 4; k++) begin
      do_reset();
      run_random();
    end

    // reset in the middle of a press
    do_reset();
    do_start();
    ld_valid = 1'b1;
    ld_data = AW'($urandom_range(1, 63));
    ld_last = 1'b0;
    n = 0;
    while (!Next && n < 50) begin
      @(negedge clock);
      n++;
    end
    ld_valid = 1'b0;
    chk("press_started", int'(Next), 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_next", int'(Next), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(ld_ready), 0);
    chk("async_rst_data", int'(input_data), 0);
    exp_q.delete();
    do_reset();
    run_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
